// File: rtl/rcon_inv.sv
// rtl/rcon_inv.sv - AES inverse round-constant sequencer (optional forward mode: RCON_INV_FWD_EN)
// Walks RCON from x^(NROUNDS-1) down to 0x01, one step per Next, with round tracking and flags.
module rcon_inv #(
  parameter int NROUNDS = 10
) (
  input  logic       ClkxCI,
  input  logic       RstxBI,
  input  logic       StartxSI,
  input  logic       NextxSI,
  input  logic       ActivexSI,
`ifdef RCON_INV_FWD_EN
  input  logic       DirxSI,
`endif
  output logic [7:0] RCONxDO,
  output logic [3:0] RoundxDO,
  output logic       BusyxSO,
  output logic       FirstRoundxSO,
  output logic       LastRoundxSO,
  output logic       FinishedxSO
);

  if (NROUNDS < 1 || NROUNDS > 10) begin : g_bad_nrounds
    $error("rcon_inv: NROUNDS must be in 1..10");
  end

  function automatic logic [7:0] f_xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  // Multiply by x^-1 mod 0x11B: v>>1, folding the dropped bit back in as 0x8D.
  function automatic logic [7:0] f_invstep(input logic [7:0] v);
    return {v[0], v[7], v[6], v[5], v[4] ^ v[0], v[3] ^ v[0], v[2], v[1] ^ v[0]};
  endfunction

  function automatic logic [7:0] f_start(input int n);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 1; i < n; i++) v = f_xtime(v);
    return v;
  endfunction

  localparam logic [7:0] START_RCON = f_start(NROUNDS);
  localparam logic [3:0] LAST_ROUND = 4'(NROUNDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t     r_state;
  logic [7:0] r_rcon;
  logic [3:0] r_round;
  logic       w_fwd;
  logic       w_start_fwd;
  logic       w_end;

`ifdef RCON_INV_FWD_EN
  logic r_dir;

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_dir <= 1'b0;
    end else if (StartxSI) begin
      r_dir <= DirxSI;
    end
  end

  assign w_fwd       = r_dir;
  assign w_start_fwd = DirxSI;
`else
  assign w_fwd       = 1'b0;
  assign w_start_fwd = 1'b0;
`endif

  assign w_end = w_fwd ? (r_round == LAST_ROUND) : (r_round == 4'd1);

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_state <= S_IDLE;
      r_rcon  <= 8'h00;
      r_round <= 4'd0;
    end else if (StartxSI) begin
      // Start always reloads, including mid-run and on a Start+Next collision.
      r_state <= S_RUN;
      r_rcon  <= w_start_fwd ? 8'h01 : START_RCON;
      r_round <= w_start_fwd ? 4'd1 : LAST_ROUND;
    end else if (NextxSI && r_state == S_RUN) begin
      if (w_end) begin
        r_state <= S_DONE;
        r_rcon  <= 8'h00;
        r_round <= 4'd0;
      end else begin
        r_rcon  <= w_fwd ? f_xtime(r_rcon) : f_invstep(r_rcon);
        r_round <= w_fwd ? r_round + 4'd1 : r_round - 4'd1;
      end
    end
  end

  assign RCONxDO       = (ActivexSI && r_state == S_RUN) ? r_rcon : 8'h00;
  assign RoundxDO      = r_round;
  assign BusyxSO       = (r_state == S_RUN);
  assign FirstRoundxSO = BusyxSO && (w_fwd ? (r_round == 4'd1) : (r_round == LAST_ROUND));
  assign LastRoundxSO  = BusyxSO && (w_fwd ? (r_round == LAST_ROUND) : (r_round == 4'd1));
  assign FinishedxSO   = (r_state == S_DONE);

endmodule

// File: tb/tb_rcon_inv.sv
// tb/tb_rcon_inv.sv - table-driven scoreboard bench for rcon_inv (N=10, plus N=8 and N=7 instances)
// Forward-mode checks are compiled in when RCON_INV_FWD_EN is defined.
module tb_rcon_inv;

  typedef struct packed {
    logic [7:0] rcon;
    logic [3:0] round;
    logic       busy;
    logic       first;
    logic       last;
    logic       fin;
  } out_t;

  typedef struct {
    logic start;
    logic next;
    logic active;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic next = 1'b0;
  logic active = 1'b0;
`ifdef RCON_INV_FWD_EN
  logic dir = 1'b0;
`endif

  logic [7:0] rc10, rc8, rc7;
  logic [3:0] rd10, rd8, rd7;
  logic b10, f10, l10, d10, b8, f8, l8, d8, b7, f7, l7, d7;

  int n_cmp = 0;
  int n_bad = 0;
  out_t  q_exp[$];
  string q_name[$];
  vec_t  tbl[$];

  logic [7:0] seq [10] = '{8'h36, 8'h1B, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  always #5 clk = ~clk;

  rcon_inv #(.NROUNDS(10)) u_dut (
    .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(start), .NextxSI(next), .ActivexSI(active),
`ifdef RCON_INV_FWD_EN
    .DirxSI(dir),
`endif
    .RCONxDO(rc10), .RoundxDO(rd10), .BusyxSO(b10), .FirstRoundxSO(f10),
    .LastRoundxSO(l10), .FinishedxSO(d10)
  );

  rcon_inv #(.NROUNDS(8)) u_dut8 (
    .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(start), .NextxSI(next), .ActivexSI(active),
`ifdef RCON_INV_FWD_EN
    .DirxSI(1'b0),
`endif
    .RCONxDO(rc8), .RoundxDO(rd8), .BusyxSO(b8), .FirstRoundxSO(f8),
    .LastRoundxSO(l8), .FinishedxSO(d8)
  );

  rcon_inv #(.NROUNDS(7)) u_dut7 (
    .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(start), .NextxSI(next), .ActivexSI(active),
`ifdef RCON_INV_FWD_EN
    .DirxSI(1'b0),
`endif
    .RCONxDO(rc7), .RoundxDO(rd7), .BusyxSO(b7), .FirstRoundxSO(f7),
    .LastRoundxSO(l7), .FinishedxSO(d7)
  );

  // Expected inverse-mode outputs for a given round; RCON for round r is always x^(r-1).
  function automatic out_t mk(input int rnd, input int n, input logic act, input logic fin);
    out_t e;
    e = '0;
    if (fin) begin
      e.fin = 1'b1;
    end else if (rnd > 0) begin
      e.rcon  = act ? seq[10-rnd] : 8'h00;
      e.round = 4'(rnd);
      e.busy  = 1'b1;
      e.first = (rnd == n);
      e.last  = (rnd == 1);
    end
    return e;
  endfunction

  function automatic out_t after_k(input int n, input int k, input logic act);
    return (k >= n) ? mk(0, n, act, 1'b1) : mk(n - k, n, act, 1'b0);
  endfunction

  function automatic vec_t mkv(input logic s, input logic nx, input logic a, input out_t e);
    vec_t v;
    v.start = s; v.next = nx; v.active = a; v.exp = e;
    return v;
  endfunction

  function automatic out_t act10();
    return {rc10, rd10, b10, f10, l10, d10};
  endfunction

  task automatic cmp(input string nm, input out_t got, input out_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got rcon=%h round=%0d busy/first/last/fin=%b%b%b%b, want rcon=%h round=%0d busy/first/last/fin=%b%b%b%b",
               nm, got.rcon, got.round, got.busy, got.first, got.last, got.fin,
               want.rcon, want.round, want.busy, want.first, want.last, want.fin);
    end
  endtask

  task automatic drive(input logic s, input logic nx, input logic a, input out_t e, input string nm);
    @(negedge clk);
    start = s; next = nx; active = a;
    q_exp.push_back(e);
    q_name.push_back(nm);
    @(posedge clk);
    #1;
    cmp(q_name.pop_front(), act10(), q_exp.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; next = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back(mkv(1'b1, 1'b0, 1'b1, mk(10, 10, 1'b1, 1'b0)));
    for (int r = 9; r >= 1; r--) tbl.push_back(mkv(1'b0, 1'b1, 1'b1, mk(r, 10, 1'b1, 1'b0)));
    tbl.push_back(mkv(1'b0, 1'b1, 1'b1, mk(0, 10, 1'b1, 1'b1)));
    tbl.push_back(mkv(1'b0, 1'b1, 1'b1, mk(0, 10, 1'b1, 1'b1)));
    tbl.push_back(mkv(1'b1, 1'b0, 1'b0, mk(10, 10, 1'b0, 1'b0)));
    for (int r = 9; r >= 1; r--) tbl.push_back(mkv(1'b0, 1'b1, 1'b0, mk(r, 10, 1'b0, 1'b0)));
    tbl.push_back(mkv(1'b0, 1'b1, 1'b0, mk(0, 10, 1'b0, 1'b1)));
    tbl.push_back(mkv(1'b0, 1'b1, 1'b1, mk(0, 10, 1'b1, 1'b1)));

    repeat (2) @(posedge clk);
    #1;
    cmp("reset_n10", act10(), '0);
    cmp("reset_n8", {rc8, rd8, b8, f8, l8, d8}, '0);
    cmp("reset_n7", {rc7, rd7, b7, f7, l7, d7}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b0, 1'b1, 1'b1, '0, "idle_next");

    for (int i = 0; i < tbl.size(); i++)
      drive(tbl[i].start, tbl[i].next, tbl[i].active, tbl[i].exp, $sformatf("tbl[%0d]", i));

    drive(1'b1, 1'b0, 1'b1, mk(10, 10, 1'b1, 1'b0), "coll_start");
    for (int r = 9; r >= 4; r--) drive(1'b0, 1'b1, 1'b1, mk(r, 10, 1'b1, 1'b0), "coll_walk");
    drive(1'b1, 1'b1, 1'b1, mk(10, 10, 1'b1, 1'b0), "coll_start_next");

    for (int r = 9; r >= 7; r--) drive(1'b0, 1'b1, 1'b1, mk(r, 10, 1'b1, 1'b0), "pre_reset_walk");
    @(negedge clk);
    start = 1'b0; next = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_reset_midrun", act10(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, mk(10, 10, 1'b1, 1'b0), "restart_after_reset");

    do_reset();
    drive(1'b1, 1'b0, 1'b1, mk(10, 10, 1'b1, 1'b0), "sweep_start");
    cmp("sweep_n8_start", {rc8, rd8, b8, f8, l8, d8}, after_k(8, 0, 1'b1));
    cmp("sweep_n7_start", {rc7, rd7, b7, f7, l7, d7}, after_k(7, 0, 1'b1));
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b1, 1'b1, after_k(10, k, 1'b1), $sformatf("sweep_n10_k%0d", k));
      cmp($sformatf("sweep_n8_k%0d", k), {rc8, rd8, b8, f8, l8, d8}, after_k(8, k, 1'b1));
      cmp($sformatf("sweep_n7_k%0d", k), {rc7, rd7, b7, f7, l7, d7}, after_k(7, k, 1'b1));
    end

`ifdef RCON_INV_FWD_EN
    do_reset();
    dir = 1'b1;
    drive(1'b1, 1'b0, 1'b1, {8'h01, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0}, "fwd_start");
    for (int r = 2; r <= 10; r++) begin
      dir = r[0];
      drive(1'b0, 1'b1, 1'b1, {seq[10-r], 4'(r), 1'b1, 1'b0, (r == 10), 1'b0},
            $sformatf("fwd_round%0d", r));
    end
    drive(1'b0, 1'b1, 1'b1, mk(0, 10, 1'b1, 1'b1), "fwd_done");
    dir = 1'b0;
`endif

    @(negedge clk);
    start = 1'b0; next = 1'b0;
    n_cmp++;
    if (q_exp.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q_exp.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
